pe_drain: RTL and testbench



---
 rtl/pe_drain.sv | 186 ++++++++++++++++++
 tb/tb_pe_drain.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pe_drain.sv
// Drain stage below the PE array bottom row: deskews per-column accumulators into a row,
// converts each lane to Q(INT_BW.FRA_BW) with saturation, buffers rows in a show-ahead FIFO.
// Optional macro PE_DRAIN_RND_EN selects round-half-up instead of truncation toward -inf.
module pe_drain #(
    parameter int COLS   = 4,
    parameter int INT_BW = 5,
    parameter int FRA_BW = 10,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_i,
    input  logic [COLS-1:0]               col_vld_i,
    input  logic [COLS*ACC_BW-1:0]        o_i,
    output logic                          out_vld_o,
    input  logic                          out_rdy_i,
    output logic [COLS*MUL_BW-1:0]        out_data_o,
    output logic [$clog2(DEPTH+1)-1:0]    cnt_o,
    output logic                          ovf_o,
    output logic                          err_o,
    output logic                          sat_o
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam int RW = COLS*MUL_BW;
    localparam int MB = INT_BW + FRA_BW;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic signed [ACC_BW:0] SAT_MAX = {{(ACC_BW+1-MB){1'b0}}, {MB{1'b1}}};
    localparam logic signed [ACC_BW:0] SAT_MIN = {{(ACC_BW+1-MB){1'b1}}, {MB{1'b0}}};
`ifdef PE_DRAIN_RND_EN
    localparam logic signed [ACC_BW:0] RND = {{(ACC_BW+1-FRA_BW){1'b0}}, 1'b1, {(FRA_BW-1){1'b0}}};
`endif

    logic [COLS-1:0]   cap_q, cap_d;
    logic [ACC_BW-1:0] lane_q [COLS];
    logic [ACC_BW-1:0] lane_d [COLS];
    logic [RW-1:0]     mem_q  [DEPTH];
    logic [RW-1:0]     mem_d  [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic [RW-1:0]     head_q, head_d;
    logic              ovf_q, ovf_d, err_q, err_d, sat_q, sat_d;

    logic [RW-1:0]     row_conv;
    logic [COLS-1:0]   lane_sat;
    logic              row_done, pop, push_ok;

    // Per-lane fixed-point conversion of the captured accumulator.
    for (genvar c = 0; c < COLS; c++) begin : g_lane
        logic signed [ACC_BW:0] ext;
        logic signed [ACC_BW:0] shf;
        logic [MUL_BW-1:0]      q;
        logic                   s;
        always_comb begin
            ext = {lane_q[c][ACC_BW-1], lane_q[c]};
`ifdef PE_DRAIN_RND_EN
            ext = ext + RND;
`endif
            shf = ext >>> FRA_BW;
            s   = 1'b0;
            q   = shf[MUL_BW-1:0];
            if (shf > SAT_MAX) begin
                q = SAT_MAX[MUL_BW-1:0];
                s = 1'b1;
            end else if (shf < SAT_MIN) begin
                q = SAT_MIN[MUL_BW-1:0];
                s = 1'b1;
            end
        end
        assign row_conv[c*MUL_BW +: MUL_BW] = q;
        assign lane_sat[c] = s;
    end

    assign row_done = &cap_q;
    assign pop      = vld_q & out_rdy_i;
    assign push_ok  = row_done & ((cnt_q != FULL_CNT) | pop);

    always_comb begin
        cap_d  = row_done ? '0 : cap_q;
        lane_d = lane_q;
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        err_d  = err_q;
        sat_d  = sat_q;

        // A strobe on the completing edge starts the next row rather than erroring.
        for (int c = 0; c < COLS; c++) begin
            if (col_vld_i[c]) begin
                if (!cap_q[c] || row_done) begin
                    lane_d[c] = o_i[c*ACC_BW +: ACC_BW];
                    cap_d[c]  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        if (pop)
            rd_d = rd_q + 1'b1;
        if (row_done) begin
            if (|lane_sat)
                sat_d = 1'b1;
            if (push_ok) begin
                mem_d[wr_q] = row_conv;
                wr_d        = wr_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // Registered head: next entry comes from the array, or from the row being written
        // when it lands in the slot the read pointer moves to.
        vld_d = (cnt_d != '0);
        if (!vld_d)
            head_d = '0;
        else if (push_ok && (rd_d == wr_q))
            head_d = row_conv;
        else
            head_d = mem_q[rd_d];

        if (clr_i) begin
            cap_d  = '0;
            for (int c = 0; c < COLS; c++)
                lane_d[c] = '0;
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            vld_d  = 1'b0;
            head_d = '0;
            ovf_d  = 1'b0;
            err_d  = 1'b0;
            sat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q  <= '0;
            for (int c = 0; c < COLS; c++)
                lane_q[c] <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            head_q <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            cap_q  <= cap_d;
            lane_q <= lane_d;
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            head_q <= head_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
            sat_q  <= sat_d;
        end
    end

    assign out_vld_o  = vld_q;
    assign out_data_o = head_q;
    assign cnt_o      = cnt_q;
    assign ovf_o      = ovf_q;
    assign err_o      = err_q;
    assign sat_o      = sat_q;

endmodule

// File: tb/tb_pe_drain.sv
// Directed bench for pe_drain: latency, conversion, saturation, rounding, FIFO overflow,
// simultaneous push/pop when full, protocol error and mid-row reset.
module tb_pe_drain;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr_i = 1'b0;
    logic [3:0]   col_vld_i = '0;
    logic [127:0] o_i = '0;
    logic         out_vld_o;
    logic         out_rdy_i = 1'b0;
    logic [63:0]  out_data_o;
    logic [2:0]   cnt_o;
    logic         ovf_o, err_o, sat_o;

    int n_chk  = 0;
    int n_fail = 0;

    pe_drain dut (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_i),
        .col_vld_i  (col_vld_i),
        .o_i        (o_i),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i),
        .out_data_o (out_data_o),
        .cnt_o      (cnt_o),
        .ovf_o      (ovf_o),
        .err_o      (err_o),
        .sat_o      (sat_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] l0, input logic [31:0] l1,
                         input logic [31:0] l2, input logic [31:0] l3);
        col_vld_i = v;
        o_i       = {l3, l2, l1, l0};
    endtask

    // Row k has lane c = (16k+c) in Q5.10 after the shift.
    task automatic drive_k(input int k);
        drive(4'hF, 32'(k*16) << 10, 32'(k*16+1) << 10, 32'(k*16+2) << 10, 32'(k*16+3) << 10);
    endtask

    function automatic logic [63:0] row_k(input int k);
        return {16'(k*16+3), 16'(k*16+2), 16'(k*16+1), 16'(k*16)};
    endfunction

    initial begin
        step();
        step();
        check("rst_vld",  64'(out_vld_o), 64'd0);
        check("rst_data", out_data_o, 64'd0);
        check("rst_cnt",  64'(cnt_o), 64'd0);
        check("rst_flags", 64'({ovf_o, err_o, sat_o}), 64'd0);
        rst = 1'b0;
        step();

        // Skewed single row: column c in cycle c, result visible at cycle 5.
        drive(4'b0001, 32'h0000_0C00, 0, 0, 0);            step();
        drive(4'b0010, 0, 32'h0018_0000, 0, 0);            step();
        drive(4'b0100, 0, 0, 32'hFFFF_FC00, 0);            step();
        drive(4'b1000, 0, 0, 0, 32'h0000_0000);            step();
        drive(4'b0000, 0, 0, 0, 0);
        check("lat_t4_vld", 64'(out_vld_o), 64'd0);
        step();
        check("lat_t5_vld", 64'(out_vld_o), 64'd1);
        check("row_basic",  out_data_o, 64'h0000_FFFF_0600_0003);
        check("cnt_one",    64'(cnt_o), 64'd1);
        check("flags_clean", 64'({ovf_o, err_o, sat_o}), 64'd0);
        out_rdy_i = 1'b1; step(); out_rdy_i = 1'b0;
        check("pop_empty_vld", 64'(out_vld_o), 64'd0);
        check("pop_empty_cnt", 64'(cnt_o), 64'd0);

        // Saturation on both ends.
        drive(4'hF, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0); step();
        drive(4'h0, 0, 0, 0, 0);                         step();
        check("row_sat", out_data_o, 64'h0000_0000_8000_7FFF);
        check("sat_flag", 64'(sat_o), 64'd1);
        out_rdy_i = 1'b1; step(); out_rdy_i = 1'b0;

        // Half-LSB values: truncation vs round-half-up.
        drive(4'hF, 32'h0000_0200, 32'hFFFF_FE00, 0, 0); step();
        drive(4'h0, 0, 0, 0, 0);                         step();
`ifdef PE_DRAIN_RND_EN
        check("row_round", out_data_o, 64'h0000_0000_0000_0001);
`else
        check("row_round", out_data_o, 64'h0000_0000_FFFF_0000);
`endif
        out_rdy_i = 1'b1; step(); out_rdy_i = 1'b0;

        clr_i = 1'b1; step(); clr_i = 1'b0;
        check("clr_sat", 64'(sat_o), 64'd0);

        // Five back-to-back rows into a stalled consumer: fifth is dropped.
        for (int k = 1; k <= 5; k++) begin
            drive_k(k);
            step();
        end
        drive(4'h0, 0, 0, 0, 0);
        step();
        check("ovf_cnt",  64'(cnt_o), 64'd4);
        check("ovf_flag", 64'(ovf_o), 64'd1);
        out_rdy_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf_drain_vld%0d", k), 64'(out_vld_o), 64'd1);
            check($sformatf("ovf_drain_row%0d", k), out_data_o, row_k(k));
            step();
        end
        check("ovf_empty_vld", 64'(out_vld_o), 64'd0);
        check("ovf_empty_cnt", 64'(cnt_o), 64'd0);
        out_rdy_i = 1'b0;

        // Full FIFO: row completes on the same edge as a pop.
        clr_i = 1'b1; step(); clr_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive_k(k);
            step();
        end
        drive(4'h0, 0, 0, 0, 0);
        check("full_cnt", 64'(cnt_o), 64'd4);
        out_rdy_i = 1'b1;
        step();
        check("pp_cnt", 64'(cnt_o), 64'd4);
        check("pp_ovf", 64'(ovf_o), 64'd0);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("pp_row%0d", k), out_data_o, row_k(k));
            step();
        end
        check("pp_empty", 64'(out_vld_o), 64'd0);
        out_rdy_i = 1'b0;

        // Double strobe on column 1: error, first value kept.
        clr_i = 1'b1; step(); clr_i = 1'b0;
        drive(4'b0010, 0, 32'h0000_0400, 0, 0);                      step();
        drive(4'b0010, 0, 32'h0000_0800, 0, 0);                      step();
        drive(4'b1101, 32'h0000_1000, 0, 32'h0000_1400, 32'h0000_1800); step();
        drive(4'h0, 0, 0, 0, 0);
        check("err_flag", 64'(err_o), 64'd1);
        step();
        check("err_vld", 64'(out_vld_o), 64'd1);
        check("err_row", out_data_o, 64'h0006_0005_0001_0004);
        out_rdy_i = 1'b1; step(); out_rdy_i = 1'b0;

        // Reset mid-row discards the partial column-0 capture.
        drive(4'b0001, 32'h0000_7C00, 0, 0, 0); step();
        drive(4'h0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("mrst_vld",   64'(out_vld_o), 64'd0);
        check("mrst_data",  out_data_o, 64'd0);
        check("mrst_cnt",   64'(cnt_o), 64'd0);
        check("mrst_flags", 64'({ovf_o, err_o, sat_o}), 64'd0);
        step();
        rst = 1'b0;
        drive(4'b1110, 0, 32'h0018_0000, 32'hFFFF_FC00, 0); step();
        drive(4'h0, 0, 0, 0, 0);                             step();
        step();
        check("mrst_partial", 64'(out_vld_o), 64'd0);
        drive(4'b0001, 32'h0000_0C00, 0, 0, 0); step();
        drive(4'h0, 0, 0, 0, 0);                 step();
        check("mrst_vld_row", 64'(out_vld_o), 64'd1);
        check("mrst_row",     out_data_o, 64'h0000_FFFF_0600_0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
